// File: rtl/axi_sram_slave_pkg.sv
// ---------------------------------------------------------------------------
// axi_sram_slave_pkg
// Shared AXI3 channel widths, burst/response codes and the FSM state
// encoding used by axi_sram_slave and axi_sram_addr_gen.
// ---------------------------------------------------------------------------
package axi_sram_slave_pkg;

  // AXI3 channel widths
  localparam int LID_W    = 4;
  localparam int LADDR_W  = 32;
  localparam int LLEN_W   = 4;
  localparam int LSIZE_W  = 3;
  localparam int LBURST_W = 2;
  localparam int LLOCK_W  = 2;
  localparam int LCACHE_W = 4;
  localparam int LPROT_W  = 3;
  localparam int LDATA_W  = 32;
  localparam int LSTRB_W  = 4;
  localparam int LRESP_W  = 2;

  // Burst type codes
  localparam logic [LBURST_W-1:0] BURST_FIXED = 2'd0;
  localparam logic [LBURST_W-1:0] BURST_INCR  = 2'd1;
  localparam logic [LBURST_W-1:0] BURST_WRAP  = 2'd2;

  // Response codes
  localparam logic [LRESP_W-1:0] RESP_OKAY   = 2'd0;
  localparam logic [LRESP_W-1:0] RESP_SLVERR = 2'd2;

  // Slave FSM states
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD    = 3'd1,
    RDV   = 3'd2,
    WR    = 3'd3,
    BRESP = 3'd4
  } state_e;

endpackage

// File: rtl/axi_sram_addr_gen.sv
// ---------------------------------------------------------------------------
// axi_sram_addr_gen
// Purely combinational beat-address generator shared by the read and write
// paths of axi_sram_slave.
//   addr_i        : current byte address
//   size_i        : AXI beat size (bytes = 1 << size)
//   burst_i       : AXI burst type
//   next_addr_o   : byte address of the following beat
//   unsupported_o : request cannot be served (WRAP, reserved burst, size > 4B)
// ---------------------------------------------------------------------------
module axi_sram_addr_gen
  import axi_sram_slave_pkg::*;
(
  input  logic [LADDR_W-1:0]  addr_i,
  input  logic [LSIZE_W-1:0]  size_i,
  input  logic [LBURST_W-1:0] burst_i,
  output logic [LADDR_W-1:0]  next_addr_o,
  output logic                unsupported_o
);

  logic [LADDR_W-1:0] incr;

  always_comb begin
    unsupported_o = (burst_i == BURST_WRAP) || (burst_i == 2'b11) || (size_i > 3'd2);
    incr          = {{(LADDR_W-1){1'b0}}, 1'b1} << size_i;
    // INCR wraps silently modulo 2^32; FIXED (and anything unsupported,
    // which never touches the SRAM) keeps the address.
    if (burst_i == BURST_INCR) begin
      next_addr_o = addr_i + incr;
    end else begin
      next_addr_o = addr_i;
    end
  end

endmodule

// File: rtl/axi_sram_slave.sv
// ---------------------------------------------------------------------------
// axi_sram_slave
// AXI3 slave driving a single-port synchronous SRAM. One burst at a time,
// fair AR/AW arbitration, ID-echoing R/B responses.
//   clk, resetn        : clock, asynchronous active-low reset
//   ar* / arready      : read address channel (lock/cache/prot ignored)
//   r* / rready        : read data channel
//   aw* / awready      : write address channel (lock/cache/prot ignored)
//   w* / wready        : write data channel (wid ignored)
//   b* / bready        : write response channel
//   sram_en/we/addr/wdata/rdata : SRAM port; rdata valid the cycle after
//                        a read strobe and held while sram_en is low
// ---------------------------------------------------------------------------
module axi_sram_slave
  import axi_sram_slave_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic                clk,
  input  logic                resetn,
  // read address
  input  logic [LID_W-1:0]    arid,
  input  logic [LADDR_W-1:0]  araddr,
  input  logic [LLEN_W-1:0]   arlen,
  input  logic [LSIZE_W-1:0]  arsize,
  input  logic [LBURST_W-1:0] arburst,
  input  logic [LLOCK_W-1:0]  arlock,
  input  logic [LCACHE_W-1:0] arcache,
  input  logic [LPROT_W-1:0]  arprot,
  input  logic                arvalid,
  output logic                arready,
  // read data
  output logic [LID_W-1:0]    rid,
  output logic [LDATA_W-1:0]  rdata,
  output logic [LRESP_W-1:0]  rresp,
  output logic                rlast,
  output logic                rvalid,
  input  logic                rready,
  // write address
  input  logic [LID_W-1:0]    awid,
  input  logic [LADDR_W-1:0]  awaddr,
  input  logic [LLEN_W-1:0]   awlen,
  input  logic [LSIZE_W-1:0]  awsize,
  input  logic [LBURST_W-1:0] awburst,
  input  logic [LLOCK_W-1:0]  awlock,
  input  logic [LCACHE_W-1:0] awcache,
  input  logic [LPROT_W-1:0]  awprot,
  input  logic                awvalid,
  output logic                awready,
  // write data
  input  logic [LID_W-1:0]    wid,
  input  logic [LDATA_W-1:0]  wdata,
  input  logic [LSTRB_W-1:0]  wstrb,
  input  logic                wlast,
  input  logic                wvalid,
  output logic                wready,
  // write response
  output logic [LID_W-1:0]    bid,
  output logic [LRESP_W-1:0]  bresp,
  output logic                bvalid,
  input  logic                bready,
  // SRAM
  output logic                sram_en,
  output logic [LSTRB_W-1:0]  sram_we,
  output logic [ADDR_W-1:0]   sram_addr,
  output logic [LDATA_W-1:0]  sram_wdata,
  input  logic [LDATA_W-1:0]  sram_rdata
);

  state_e               state_q, state_d;
  logic [LID_W-1:0]     id_q, id_d;
  logic [LADDR_W-1:0]   addr_q, addr_d;
  logic [LLEN_W-1:0]    len_q, len_d;
  logic [LSIZE_W-1:0]   size_q, size_d;
  logic [LBURST_W-1:0]  burst_q, burst_d;
  logic [LLEN_W-1:0]    beat_q, beat_d;
  logic                 err_q, err_d;     // response is SLVERR
  logic                 unsup_q, unsup_d; // burst never touches the SRAM
  logic                 last_rd_q, last_rd_d;

  logic                 grant_rd, grant_wr, last_beat;
  logic [LADDR_W-1:0]   ag_addr, ag_next;
  logic [LSIZE_W-1:0]   ag_size;
  logic [LBURST_W-1:0]  ag_burst;
  logic                 ag_unsup;

  logic unused_inputs;
  assign unused_inputs = ^{arlock, arcache, arprot, awlock, awcache, awprot, wid};

  // Read wins when it is the only request, or when both are pending and the
  // previous grant went to a write.
  assign grant_rd  = arvalid && (!awvalid || !last_rd_q);
  assign grant_wr  = awvalid && !grant_rd;
  assign last_beat = (beat_q == len_q);

  // In IDLE the generator looks at the request being granted so its
  // unsupported flag can be captured; afterwards it steps the burst.
  always_comb begin
    ag_addr  = addr_q;
    ag_size  = size_q;
    ag_burst = burst_q;
    if (state_q == IDLE) begin
      if (grant_rd) begin
        ag_addr  = araddr;
        ag_size  = arsize;
        ag_burst = arburst;
      end else begin
        ag_addr  = awaddr;
        ag_size  = awsize;
        ag_burst = awburst;
      end
    end
  end

  axi_sram_addr_gen u_addr_gen (
    .addr_i        (ag_addr),
    .size_i        (ag_size),
    .burst_i       (ag_burst),
    .next_addr_o   (ag_next),
    .unsupported_o (ag_unsup)
  );

  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    addr_d     = addr_q;
    len_d      = len_q;
    size_d     = size_q;
    burst_d    = burst_q;
    beat_d     = beat_q;
    err_d      = err_q;
    unsup_d    = unsup_q;
    last_rd_d  = last_rd_q;
    arready    = 1'b0;
    awready    = 1'b0;
    wready     = 1'b0;
    rvalid     = 1'b0;
    rid        = '0;
    rdata      = '0;
    rresp      = RESP_OKAY;
    rlast      = 1'b0;
    bvalid     = 1'b0;
    bid        = '0;
    bresp      = RESP_OKAY;
    sram_en    = 1'b0;
    sram_we    = '0;
    sram_addr  = '0;
    sram_wdata = '0;

    unique case (state_q)
      IDLE: begin
        arready = grant_rd;
        awready = grant_wr;
        if (grant_rd || grant_wr) begin
          id_d      = grant_rd ? arid    : awid;
          addr_d    = grant_rd ? araddr  : awaddr;
          len_d     = grant_rd ? arlen   : awlen;
          size_d    = grant_rd ? arsize  : awsize;
          burst_d   = grant_rd ? arburst : awburst;
          beat_d    = '0;
          err_d     = ag_unsup;
          unsup_d   = ag_unsup;
          last_rd_d = grant_rd;
          state_d   = grant_rd ? RD : WR;
        end
      end

      RD: begin
        sram_en   = !unsup_q;
        sram_addr = addr_q[ADDR_W+1:2];
        state_d   = RDV;
      end

      // sram_en stays low here, so the SRAM keeps rdata stable under stall.
      RDV: begin
        rvalid = 1'b1;
        rid    = id_q;
        rdata  = err_q ? '0 : sram_rdata;
        rresp  = err_q ? RESP_SLVERR : RESP_OKAY;
        rlast  = last_beat;
        if (rready) begin
          if (last_beat) begin
            state_d = IDLE;
          end else begin
            addr_d  = ag_next;
            beat_d  = beat_q + 1'b1;
            state_d = RD;
          end
        end
      end

      WR: begin
        wready = 1'b1;
        if (wvalid) begin
          sram_en    = !unsup_q;
          sram_we    = unsup_q ? '0 : wstrb;
          sram_wdata = unsup_q ? '0 : wdata;
          sram_addr  = unsup_q ? '0 : addr_q[ADDR_W+1:2];
          // A misplaced wlast only poisons the response; len still rules.
          if (wlast != last_beat) begin
            err_d = 1'b1;
          end
          if (last_beat) begin
            state_d = BRESP;
          end else begin
            addr_d = ag_next;
            beat_d = beat_q + 1'b1;
          end
        end
      end

      BRESP: begin
        bvalid = 1'b1;
        bid    = id_q;
        bresp  = err_q ? RESP_SLVERR : RESP_OKAY;
        if (bready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      beat_q    <= '0;
      err_q     <= 1'b0;
      unsup_q   <= 1'b0;
      last_rd_q <= 1'b1; // write wins the first tie after reset
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      size_q    <= size_d;
      burst_q   <= burst_d;
      beat_q    <= beat_d;
      err_q     <= err_d;
      unsup_q   <= unsup_d;
      last_rd_q <= last_rd_d;
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
module tb_axi_sram_slave;
  import axi_sram_slave_pkg::*;

  localparam int ADDR_W = 16;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic [LID_W-1:0]    arid, rid, awid, wid, bid;
  logic [LADDR_W-1:0]  araddr, awaddr;
  logic [LLEN_W-1:0]   arlen, awlen;
  logic [LSIZE_W-1:0]  arsize, awsize;
  logic [LBURST_W-1:0] arburst, awburst;
  logic [LLOCK_W-1:0]  arlock, awlock;
  logic [LCACHE_W-1:0] arcache, awcache;
  logic [LPROT_W-1:0]  arprot, awprot;
  logic                arvalid, arready, awvalid, awready;
  logic [LDATA_W-1:0]  rdata, wdata;
  logic [LRESP_W-1:0]  rresp, bresp;
  logic                rlast, rvalid, rready;
  logic [LSTRB_W-1:0]  wstrb;
  logic                wlast, wvalid, wready;
  logic                bvalid, bready;
  logic                sram_en;
  logic [LSTRB_W-1:0]  sram_we;
  logic [ADDR_W-1:0]   sram_addr;
  logic [LDATA_W-1:0]  sram_wdata, sram_rdata;

  axi_sram_slave #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .resetn(resetn),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  // SRAM model driven by the DUT, and a reference image kept by the bench
  logic [31:0] sram_mem [0:65535];
  logic [31:0] ref_mem  [0:65535];
  int en_cnt = 0;

  always @(posedge clk) begin
    if (sram_en) begin
      en_cnt++;
      if (sram_we == 4'h0) begin
        sram_rdata <= sram_mem[sram_addr];
      end else begin
        for (int k = 0; k < 4; k++)
          if (sram_we[k]) sram_mem[sram_addr][8*k +: 8] <= sram_wdata[8*k +: 8];
      end
    end
  end

  typedef struct {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } rexp_t;
  typedef struct {
    logic [3:0] id;
    logic [1:0] resp;
  } bexp_t;
  rexp_t r_q[$];
  bexp_t b_q[$];

  typedef struct {
    bit          wr;
    logic [3:0]  id;
    logic [31:0] addr;
    logic [3:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [31:0] dbase;
    logic [31:0] dstep;
    logic [3:0]  strb;
    int          early;
    int          stall;
    bit          lat;
    logic [1:0]  resp;
  } vec_t;
  vec_t tv[16];

  int total = 0;
  int bad = 0;

  logic [31:0] w_addr;
  logic [3:0]  w_len;
  logic [2:0]  w_size;
  logic [1:0]  w_burst;
  bit          w_unsup;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] nxt(input logic [31:0] a, input logic [2:0] size, input logic [1:0] burst);
    return (burst == BURST_INCR) ? a + (32'd1 << size) : a;
  endfunction

  function automatic bit is_unsup(input logic [2:0] size, input logic [1:0] burst);
    return burst[1] || (size > 3'd2);
  endfunction

  function automatic logic [38:0] outs_ctrl();
    return {arready, awready, wready, rvalid, bvalid, rid, rresp, rlast, bid, bresp,
            sram_en, sram_we, sram_addr};
  endfunction

  task automatic start_ar(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input logic [1:0] resp);
    logic [31:0] a;
    rexp_t e;
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    a = addr;
    for (int b = 0; b <= int'(len); b++) begin
      e.id   = id;
      e.data = (resp == RESP_SLVERR) ? 32'h0 : ref_mem[a[17:2]];
      e.resp = resp;
      e.last = (b == int'(len));
      r_q.push_back(e);
      a = nxt(a, size, burst);
    end
  endtask

  task automatic start_aw(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input logic [1:0] resp,
                          input bit push_b);
    bexp_t e;
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    w_addr = addr; w_len = len; w_size = size; w_burst = burst; w_unsup = is_unsup(size, burst);
    e.id = id; e.resp = resp;
    if (push_b) b_q.push_back(e);
  endtask

  task automatic wait_ar_hs();
    int n = 0;
    @(negedge clk);
    while (!arready && n < 50) begin @(negedge clk); n++; end
    if (!arready) chk("ar_handshake_timeout", 0, 1);
    @(posedge clk); #1;
    arvalid = 1'b0;
  endtask

  task automatic wait_aw_hs();
    int n = 0;
    @(negedge clk);
    while (!awready && n < 50) begin @(negedge clk); n++; end
    if (!awready) chk("aw_handshake_timeout", 0, 1);
    @(posedge clk); #1;
    awvalid = 1'b0;
  endtask

  task automatic w_send(input logic [31:0] base, input logic [31:0] step, input logic [3:0] strb,
                        input int nbeats, input int early);
    logic [31:0] a, d;
    int n;
    a = w_addr;
    for (int b = 0; b < nbeats; b++) begin
      d = base + step * b;
      wvalid = 1'b1; wdata = d; wstrb = strb;
      wlast = (early >= 0) ? (b == early) : (b == int'(w_len));
      n = 0;
      @(negedge clk);
      while (!wready && n < 50) begin @(negedge clk); n++; end
      if (!wready) chk("w_handshake_timeout", 0, 1);
      @(posedge clk); #1;
      if (!w_unsup)
        for (int k = 0; k < 4; k++)
          if (strb[k]) ref_mem[a[17:2]][8*k +: 8] = d[8*k +: 8];
      a = nxt(a, w_size, w_burst);
    end
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic collect_r(input int nbeats, input int stall, input bit chk_lat);
    int lat, c0;
    rexp_t e;
    logic [36:0] held;
    for (int b = 0; b < nbeats; b++) begin
      rready = (b != stall);
      lat = 0;
      do begin @(negedge clk); lat++; end while (!rvalid && lat < 50);
      if (!rvalid) begin
        chk("r_valid_timeout", 0, 1);
        return;
      end
      if (chk_lat && b == 0) chk("r_latency", lat, 2);
      if (r_q.size() == 0) begin
        chk("r_unexpected_beat", 1, 0);
      end else begin
        e = r_q.pop_front();
        chk("rdata", rdata, e.data);
        chk("rresp", rresp, e.resp);
        chk("rid", rid, e.id);
        chk("rlast", rlast, e.last);
      end
      if (b == stall) begin
        held = {rid, rlast, rdata};
        c0 = en_cnt;
        repeat (5) begin
          @(negedge clk);
          chk("r_hold", {rvalid, rid, rlast, rdata}, {1'b1, held});
        end
        chk("r_hold_no_sram_en", en_cnt, c0);
        rready = 1'b1;
      end
      @(posedge clk); #1;
    end
    rready = 1'b1;
  endtask

  task automatic collect_b(input bit chk_lat);
    int lat = 0;
    bexp_t e;
    bready = 1'b1;
    do begin @(negedge clk); lat++; end while (!bvalid && lat < 50);
    if (!bvalid) begin
      chk("b_valid_timeout", 0, 1);
      return;
    end
    if (chk_lat) chk("b_latency", lat, 1);
    if (b_q.size() == 0) begin
      chk("b_unexpected", 1, 0);
    end else begin
      e = b_q.pop_front();
      chk("bid", bid, e.id);
      chk("bresp", bresp, e.resp);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got still running expected finished");
    $fatal(1);
  end

  initial begin
    int c0, exp_en;
    for (int i = 0; i < 65536; i++) begin sram_mem[i] = 32'h0; ref_mem[i] = 32'h0; end
    sram_mem[4]      = 32'hDEADBEEF; ref_mem[4]      = 32'hDEADBEEF;
    sram_mem[16'hFFFF] = 32'h12345678; ref_mem[16'hFFFF] = 32'h12345678;
    sram_mem[0]      = 32'hCAFEF00D; ref_mem[0]      = 32'hCAFEF00D;
    sram_rdata = 32'h0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arlock = '0; arcache = '0;
    arprot = '0; arvalid = 1'b0; rready = 1'b1;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awlock = '0; awcache = '0;
    awprot = '0; awvalid = 1'b0;
    wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b1;

    //        wr id    addr          len size burst        dbase         dstep strb early stall lat resp
    tv[0]  = '{0, 4'd3,  32'h10,       4'd0, 3'd2, BURST_INCR,  32'h0,        32'h0, 4'hF, -1, -1, 1, RESP_OKAY};
    tv[1]  = '{1, 4'd5,  32'h100,      4'd3, 3'd2, BURST_INCR,  32'h1,        32'h1, 4'hF, -1, -1, 1, RESP_OKAY};
    tv[2]  = '{0, 4'd6,  32'h100,      4'd3, 3'd2, BURST_INCR,  32'h0,        32'h0, 4'hF, -1, -1, 1, RESP_OKAY};
    tv[3]  = '{0, 4'd7,  32'h100,      4'd3, 3'd2, BURST_INCR,  32'h0,        32'h0, 4'hF, -1,  1, 0, RESP_OKAY};
    tv[4]  = '{1, 4'd2,  32'h200,      4'd2, 3'd2, BURST_FIXED, 32'hA0,       32'h1, 4'hF, -1, -1, 1, RESP_OKAY};
    tv[5]  = '{0, 4'd8,  32'h200,      4'd1, 3'd2, BURST_FIXED, 32'h0,        32'h0, 4'hF, -1, -1, 0, RESP_OKAY};
    tv[6]  = '{0, 4'd9,  32'h100,      4'd3, 3'd2, BURST_WRAP,  32'h0,        32'h0, 4'hF, -1, -1, 0, RESP_SLVERR};
    tv[7]  = '{1, 4'd4,  32'h300,      4'd3, 3'd2, BURST_INCR,  32'h30,       32'h1, 4'hF,  1, -1, 0, RESP_SLVERR};
    tv[8]  = '{0, 4'd10, 32'h300,      4'd3, 3'd2, BURST_INCR,  32'h0,        32'h0, 4'hF, -1, -1, 0, RESP_OKAY};
    tv[9]  = '{1, 4'd1,  32'h300,      4'd0, 3'd3, BURST_INCR,  32'h99,       32'h0, 4'hF, -1, -1, 0, RESP_SLVERR};
    tv[10] = '{0, 4'd11, 32'h300,      4'd0, 3'd2, BURST_INCR,  32'h0,        32'h0, 4'hF, -1, -1, 0, RESP_OKAY};
    tv[11] = '{0, 4'd12, 32'h101,      4'd3, 3'd0, BURST_INCR,  32'h0,        32'h0, 4'hF, -1, -1, 0, RESP_OKAY};
    tv[12] = '{1, 4'd13, 32'h100,      4'd0, 3'd2, BURST_INCR,  32'hFFFFFFFF, 32'h0, 4'h3, -1, -1, 0, RESP_OKAY};
    tv[13] = '{0, 4'd14, 32'h100,      4'd0, 3'd2, BURST_INCR,  32'h0,        32'h0, 4'hF, -1, -1, 0, RESP_OKAY};
    tv[14] = '{0, 4'd15, 32'hFFFFFFFC, 4'd1, 3'd2, BURST_INCR,  32'h0,        32'h0, 4'hF, -1, -1, 0, RESP_OKAY};
    tv[15] = '{0, 4'd0,  32'h40,       4'd1, 3'd2, 2'b11,       32'h0,        32'h0, 4'hF, -1, -1, 0, RESP_SLVERR};

    // Reset state
    #12;
    chk("reset_ctrl_in_reset", {25'h0, outs_ctrl()}, 64'h0);
    chk("reset_data_in_reset", {rdata, sram_wdata}, 64'h0);
    @(negedge clk); resetn = 1'b1;
    @(posedge clk); #1;
    chk("reset_ctrl_after", {25'h0, outs_ctrl()}, 64'h0);

    // Table-driven transactions
    for (int i = 0; i < 16; i++) begin
      c0 = en_cnt;
      exp_en = is_unsup(tv[i].size, tv[i].burst) ? 0 : int'(tv[i].len) + 1;
      if (tv[i].wr) begin
        start_aw(tv[i].id, tv[i].addr, tv[i].len, tv[i].size, tv[i].burst, tv[i].resp, 1);
        wait_aw_hs();
        w_send(tv[i].dbase, tv[i].dstep, tv[i].strb, int'(tv[i].len) + 1, tv[i].early);
        collect_b(tv[i].lat);
      end else begin
        start_ar(tv[i].id, tv[i].addr, tv[i].len, tv[i].size, tv[i].burst, tv[i].resp);
        wait_ar_hs();
        collect_r(int'(tv[i].len) + 1, tv[i].stall, tv[i].lat);
      end
      chk($sformatf("v%0d_sram_en_pulses", i), en_cnt - c0, exp_en);
      $display("vec %0d %s id=%0d addr=%h len=%0d size=%0d burst=%0d resp=%0d",
               i, tv[i].wr ? "WRITE" : "READ", tv[i].id, tv[i].addr, tv[i].len,
               tv[i].size, tv[i].burst, tv[i].resp);
    end

    // Arbitration: last grant was a read, so a tie goes to the write, then the read
    start_ar(4'hA, 32'h10, 4'd0, 3'd2, BURST_INCR, RESP_OKAY);
    start_aw(4'hB, 32'h500, 4'd0, 3'd2, BURST_INCR, RESP_OKAY, 1);
    @(negedge clk);
    chk("arb1_awready", awready, 1);
    chk("arb1_arready", arready, 0);
    @(posedge clk); #1; awvalid = 1'b0;
    w_send(32'h55, 32'h0, 4'hF, 1, -1);
    collect_b(0);
    start_aw(4'hC, 32'h504, 4'd0, 3'd2, BURST_INCR, RESP_OKAY, 1);
    @(negedge clk);
    chk("arb2_arready", arready, 1);
    chk("arb2_awready", awready, 0);
    @(posedge clk); #1; arvalid = 1'b0;
    collect_r(1, -1, 0);
    wait_aw_hs();
    w_send(32'h66, 32'h0, 4'hF, 1, -1);
    collect_b(0);
    $display("arb sequence: write id=11, read id=10, write id=12");

    // Reset in the middle of a 4-beat write, after 2 beats
    start_aw(4'h3, 32'h400, 4'd3, 3'd2, BURST_INCR, RESP_OKAY, 0);
    wait_aw_hs();
    w_send(32'h40, 32'h1, 4'hF, 2, -1);
    wvalid = 1'b1; wdata = 32'h42; wstrb = 4'hF;
    #1;
    chk("pre_reset_sram_en", sram_en, 1);
    resetn = 1'b0;
    #1;
    chk("mid_reset_ctrl", {25'h0, outs_ctrl()}, 64'h0);
    chk("mid_reset_data", {rdata, sram_wdata}, 64'h0);
    wvalid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); resetn = 1'b1;
    @(posedge clk); #1;
    $display("reset mid-burst after 2 of 4 write beats");

    // After reset a tie goes to the write; then the partial burst reads back
    start_ar(4'h8, 32'h400, 4'd3, 3'd2, BURST_INCR, RESP_OKAY);
    start_aw(4'h7, 32'h600, 4'd0, 3'd2, BURST_INCR, RESP_OKAY, 1);
    @(negedge clk);
    chk("post_reset_awready", awready, 1);
    chk("post_reset_arready", arready, 0);
    @(posedge clk); #1; awvalid = 1'b0;
    w_send(32'h77, 32'h0, 4'hF, 1, -1);
    collect_b(0);
    wait_ar_hs();
    collect_r(4, -1, 0);
    $display("post-reset write id=7 then read id=8 addr=00000400 len=3");

    chk("scoreboard_empty", r_q.size() + b_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_sram_slave.md
# axi_sram_slave

AXI3 slave that terminates the CPU's AXI master port and drives a single-port synchronous SRAM. Accepts one read or one write burst at a time (no outstanding overlap), arbitrates fairly between AR and AW, and produces R/B responses with echoed IDs. Sits directly downstream of `cpu`; all AXI widths come from the shared `defines.vh` (`L*` macros).

## Interface
- `ADDR_W`, 16: SRAM word-address width. Byte address bits `[ADDR_W+1:2]` select the word; higher bits are ignored (aliasing).
- `clk`  in  1: single clock.
- `resetn`  in  1: asynchronous, active-low reset.
- `arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot/arvalid`  in  `` `L* `` widths: read address channel. lock, cache and prot are ignored.
- `arready`  out  1.
- `rid/rdata/rresp/rlast/rvalid`  out  `` `L* `` widths: read data channel.
- `rready`  in  1.
- `awid/awaddr/awlen/awsize/awburst/awlock/awcache/awprot/awvalid`  in  `` `L* `` widths: write address channel.
- `awready`  out  1.
- `wid/wdata/wstrb/wlast/wvalid`  in  `` `L* `` widths. `wid` is ignored.
- `wready`  out  1.
- `bid/bresp/bvalid`  out  `` `L* `` widths.
- `bready`  in  1.
- `sram_en`  out  1: access strobe.
- `sram_we`  out  4: byte write enables; all zero means read.
- `sram_addr`  out  `ADDR_W`: word address.
- `sram_wdata`  out  32.
- `sram_rdata`  in  32: valid the cycle after a read strobe. The SRAM holds its output while `sram_en` is low.

## Operation
- FSM states: IDLE, RD, RDV, WR, BRESP.
- Reset state is IDLE. All valid/ready outputs are 0. `rid/rdata/rresp/rlast/bid/bresp` are 0. `sram_en`, `sram_we`, `sram_addr` and `sram_wdata` are 0.
- IDLE:
  - Grant AR or AW. If both are valid, alternate using a `last_rd` flag; after reset, write wins first.
  - `arready = IDLE & arvalid & grant_rd`. `awready` is the mirror of this.
  - On handshake, capture id, addr, len, size and burst; clear the beat counter and the error flag.
- Unsupported request (error flag set):
  - Triggers: burst == WRAP (2'b10), burst == 2'b11, or size > 2.
  - No SRAM access for the whole burst. Read beats return `rdata = 0`, `rresp = SLVERR` (2'b10). Write returns `bresp = SLVERR`.
- RD:
  - `sram_en = 1`, `sram_we = 0`, `sram_addr` = current beat address.
  - Suppress `sram_en` if the error flag is set.
  - Always go to RDV next cycle.
- RDV:
  - `rvalid = 1`; `rdata` = `sram_rdata` (0 if error); `rresp` = OKAY or SLVERR; `rid` = captured id; `rlast = (beat == len)`.
  - Hold all R outputs until `rready`.
  - On handshake: if last, go to IDLE; else advance the address, increment beat, go to RD.
- WR:
  - `wready = 1`.
  - On `wvalid`: `sram_en = 1` (combinational, same cycle), `sram_we = wstrb`, `sram_wdata = wdata`, `sram_addr` = current address. Then advance.
  - On the beat where `beat == len`, go to BRESP.
  - If `wlast != (beat == len)` on any accepted beat, set the error flag. That beat is still written; the burst length is governed by `len` only.
- BRESP:
  - `bvalid = 1`; `bid` = captured id; `bresp` = SLVERR if error, else OKAY.
  - On `bready`, go to IDLE.
- Address generation:
  - FIXED: the address is constant.
  - INCR: the byte address increments by `1 << size` per beat. The sum wraps silently modulo 2^32.
- Reset mid-burst aborts immediately to IDLE. The partial write stands.

## Timing
- Read: AR handshake at edge T → RD in cycle T+1 → RDV (`rvalid`) in cycle T+2. With `rready` held high: 2 cycles per beat; a 16-beat burst takes 32 cycles.
- Write: AW handshake at edge T → `wready` in cycle T+1. One beat per cycle while `wvalid` is held. `bvalid` appears the cycle after the last beat.
- IDLE occupies one cycle between bursts. `arready`/`awready` are never asserted outside IDLE.
- Outputs are held stable while valid is high and ready is low.

## Structure
- `defines.vh` additions:
  - Burst codes: `BURST_FIXED` = 0, `BURST_INCR` = 1, `BURST_WRAP` = 2.
  - Response codes: `RESP_OKAY` = 0, `RESP_SLVERR` = 2.
  - FSM state encodings.
- Sub-module `axi_sram_addr_gen`: inputs are the current address, size and burst; outputs are the next byte address and an `unsupported` flag. Purely combinational; shared by the read and write paths.

## Test plan
- Single read: araddr = 0x10, len = 0, SRAM word 4 preloaded with 0xDEADBEEF → `rdata = 0xDEADBEEF`, `rlast = 1`, `rresp = 0`, `rid` echoed; `rvalid` 2 cycles after the handshake.
- Write then read back: 4-beat INCR at 0x100, size = 2, data 1..4, `wstrb = 0xF` → `bresp = 0`. Readback returns 1, 2, 3, 4 with `rlast` only on beat 3.
- Read backpressure: `rready` low for 5 cycles on beat 1 → `rdata`, `rlast` and `rid` are held constant; no extra `sram_en`.
- Arbitration: `arvalid` and `awvalid` asserted together twice → write granted first, then read.
- Errors:
  - WRAP read, len = 3 → 4 beats with SLVERR and `rdata = 0`, zero `sram_en` pulses.
  - Write with early `wlast` → `bresp = SLVERR`.
- Reset mid-burst: assert `resetn` low in WR after 2 of 4 beats → all outputs return to 0 asynchronously. After release, a new read succeeds.
